// File: rtl/btn_cond_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM states,
// default parameter values and a counter-width helper.
// Optional feature macro: BTN_COND_REPEAT_EN (auto-repeat press while held).
package btn_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } ch_state_e;

  localparam int unsigned DEF_N_CH            = 5;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One conditioner channel: synchroniser, debounce counter and
// RELEASED/PRESSED/HELD FSM producing registered level and event pulses.
// Optional feature macro: BTN_COND_REPEAT_EN adds auto-repeat press pulses
// every REPEAT_CYCLES while the channel is in HELD.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   btn_i      raw asynchronous pin
//   level_o    debounced level
//   press_o    1-cycle pulse on debounced rise (and auto-repeat)
//   release_o  1-cycle pulse on debounced fall
//   hold_o     1-cycle pulse on entry to HELD
//   held_o     high while in HELD
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic held_o
);

  localparam int unsigned DCNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned HCNT_W = cnt_w(HOLD_CYCLES);

  // Elaboration-time parameter sanity check.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || HOLD_CYCLES <= DEBOUNCE_CYCLES ||
      REPEAT_CYCLES < 2) begin : g_bad_params
    $error("btn_channel: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_c;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   hold_q, hold_d;
  logic                   held_q, held_d;
  logic                   rise_c, fall_c;
  ch_state_e              state_q, state_d;

`ifdef BTN_COND_REPEAT_EN
  localparam int unsigned RCNT_W = cnt_w(REPEAT_CYCLES);
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
`endif

  assign s_c = sync_q[SYNC_STAGES-1];

  // Debounce, FSM next-state and event generation.
  always_comb begin
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;
`ifdef BTN_COND_REPEAT_EN
    rcnt_d    = rcnt_q;
`endif

    // Any return of s to level before the window expires restarts the window.
    if (s_c == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
      dcnt_d  = '0;
      level_d = ~level_q;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end

    // Events key off level_d so pulses line up with the level_o change.
    rise_c = level_d & ~level_q;
    fall_c = ~level_d & level_q;

    case (state_q)
      RELEASED: begin
        if (rise_c) begin
          state_d = PRESSED;
          press_d = 1'b1;
          hcnt_d  = '0;
        end
      end
      PRESSED: begin
        if (fall_c) begin
          state_d   = RELEASED;
          release_d = 1'b1;
          hcnt_d    = '0;
        end else if (hcnt_q == HCNT_W'(HOLD_CYCLES - 1)) begin
          state_d = HELD;
          hold_d  = 1'b1;
`ifdef BTN_COND_REPEAT_EN
          rcnt_d  = '0;
`endif
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      HELD: begin
        if (fall_c) begin
          state_d   = RELEASED;
          release_d = 1'b1;
          hcnt_d    = '0;
`ifdef BTN_COND_REPEAT_EN
          rcnt_d    = '0;
        end else if (rcnt_q == RCNT_W'(REPEAT_CYCLES - 1)) begin
          press_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
`endif
        end
      end
      default: begin
        state_d = RELEASED;
        hcnt_d  = '0;
      end
    endcase

    held_d = (state_d == HELD);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      held_q    <= 1'b0;
      state_q   <= RELEASED;
`ifdef BTN_COND_REPEAT_EN
      rcnt_q    <= '0;
`endif
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      held_q    <= held_d;
      state_q   <= state_d;
`ifdef BTN_COND_REPEAT_EN
      rcnt_q    <= rcnt_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;
  assign held_o    = held_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel pushbutton/switch conditioner: each channel is synchronised,
// debounced and decoded into level plus press/release/long-press events.
// Optional feature macro: BTN_COND_REPEAT_EN enables auto-repeat press pulses
// while a channel is held.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   btn_i      raw asynchronous pins, one per channel
//   level_o    debounced levels
//   press_o    press pulses (debounced rise, plus auto-repeat when enabled)
//   release_o  release pulses
//   hold_o     long-press pulses
//   held_o     high while a channel is in HELD
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_CH            = DEF_N_CH,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] hold_o,
  output logic [N_CH-1:0] held_o
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("button_conditioner: N_CH must be 1..32");
  end

  // Independent channels, one per pin.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .btn_i    (btn_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .hold_o   (hold_o[g]),
      .held_o   (held_o[g])
    );
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised N-channel input conditioner, successor to the fixed five-button debouncer on the Nexys A7 top level. Each channel synchronises a raw pushbutton or switch pin, debounces it with a configurable stability window, and emits a clean level plus single-cycle press, release and long-press events. It sits between the board pins and the state/control logic and replaces the per-button debounce path for buttons and, optionally, slide switches.

## Interface
- N_CH, 5: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 1_000_000: stability window in clk_i cycles (10 ms at 100 MHz); ≥2.
- HOLD_CYCLES, 50_000_000: cycles of debounced-high before long-press; > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 10_000_000: auto-repeat period while held; ≥2; used only with repeat compiled in.

- clk_i  in  1  system clock (CLK100MHZ).
- rst_i  in  1  synchronous, active-high reset.
- btn_i  in  N_CH  raw asynchronous pins.
- level_o  out  N_CH  debounced level.
- press_o  out  N_CH  1-cycle pulse on debounced rise (and on auto-repeat).
- release_o  out  N_CH  1-cycle pulse on debounced fall.
- hold_o  out  N_CH  1-cycle pulse when long-press threshold reached.
- held_o  out  N_CH  high while channel is in HELD.

## Operation
- Channels fully independent; no priority, no shared counters.
- Sync: btn_i passes SYNC_STAGES flops → s (per channel).
- Debounce counter dcnt, width $clog2(DEBOUNCE_CYCLES): cleared when s == level; incremented when s != level; when s != level and dcnt == DEBOUNCE_CYCLES-1, level toggles on next edge and dcnt clears. Any return of s to level before that clears dcnt (glitch rejected).
- Per-channel FSM (states in package): RELEASED, PRESSED, HELD.
  - RELEASED → PRESSED on level rise; press_o pulses; hold counter hcnt cleared.
  - PRESSED: hcnt increments each cycle; at hcnt == HOLD_CYCLES-1 → HELD, hold_o pulses, rcnt cleared.
  - HELD: held_o = 1; repeat behaviour per Configuration.
  - PRESSED/HELD → RELEASED on level fall; release_o pulses; hcnt, rcnt cleared.
- Counters saturate never; they are cleared by the transitions above, so no wrap-around is reachable.
- press_o and release_o never both high for a channel in one cycle; hold_o and repeat press_o never coincide (repeat first fires REPEAT_CYCLES after entering HELD).

## Timing
- Reset: all sync flops, level_o, press_o, release_o, hold_o, held_o, dcnt, hcnt, rcnt = 0; FSM = RELEASED. Takes effect on the edge where rst_i is sampled high.
- Reset mid-operation: channel returns to RELEASED with no release_o; a pin still high after reset is re-detected as a fresh press (press_o fires).
- Latency pin edge → level_o/press_o/release_o: SYNC_STAGES + DEBOUNCE_CYCLES cycles for a clean edge.
- level rise → hold_o: HOLD_CYCLES cycles.
- All outputs registered; event pulses exactly one cycle wide, aligned with level_o change (press/release) or state entry (hold).

## Configuration
- BTN_COND_REPEAT_EN defined: in HELD, rcnt counts; at rcnt == REPEAT_CYCLES-1, press_o pulses and rcnt clears; continues until release.
- Undefined: rcnt and repeat logic absent; press_o fires only on debounced rise; REPEAT_CYCLES ignored.

## Structure
- Package btn_cond_pkg: FSM state enum typedef (RELEASED, PRESSED, HELD), default parameter constants, counter-width helper.
- Sub-module btn_channel: one channel (sync, debounce, FSM, counters); top instantiates N_CH copies via generate and concatenates outputs.

## Test plan
Params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, N_CH=5.
- btn_i[0] 0→1 at cycle 0, held → level_o[0]=1 and press_o[0] 1-cycle pulse at cycle 6; other channels stay 0.
- btn_i[2] high for 3 cycles then low → level_o[2], press_o[2] never assert.
- btn_i[1] bounce 1,0,1,1,0 then steady 1 from cycle 5 → single press_o[1] at cycle 11; release after steady 0 gives exactly one release_o[1].
- Hold btn_i[3] → hold_o[3] pulse 20 cycles after level rise, held_o[3]=1; with BTN_COND_REPEAT_EN press_o[3] at +25, +30, +35…; without it no further press_o.
- rst_i pulsed while channel 3 in HELD → all outputs 0 next cycle, no release_o; pin still high → press_o[3] again 6 cycles after rst_i deasserts.
- btn_i[0] and btn_i[4] rise same cycle → press_o[0] and press_o[4] pulse in the same cycle.
